// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: four-channel ESC servo-PWM driver behind the PID mixer.
// Rates are saturated to 0..RANGE, captured into shadow registers on
// rates_valid and promoted to the active registers only at a frame
// boundary, so a pulse never changes width mid-frame. An arming FSM holds
// MIN pulses for ARM_FRAMES frames before ARMED, and a watchdog faults the
// outputs to MIN pulses when rates stop arriving.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   motor1..4_rate          mixer rates, 2's complement, BIT_WIDTH each
//   rates_valid             one-cycle strobe, all four rates valid
//   arm_req                 level, high requests arming
//   pwm[3:0]                ESC pulses, bit i = motor i+1
//   armed, fault            registered state flags
//   frame_start             one-cycle pulse at each frame boundary

// Per-motor lane: conditioning, shadow/active rate and pulse generator.
module motor_pwm_lane #(
  parameter int BIT_WIDTH    = 16,
  parameter int RANGE        = 1000,
  parameter int RW           = 10,
  parameter int PW           = 11,
  parameter int UW           = 12,
  parameter int MIN_PULSE_US = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] rate,
  input  logic                 rates_valid,
  input  logic                 load_act,
  input  logic                 clr_act,
  input  logic                 out_en,
  input  logic                 add_rate,
  input  logic [UW-1:0]        us_cnt,
  output logic                 pwm
);
  logic [RW-1:0] cond;
  logic [RW-1:0] shadow_d, shadow_q;
  logic [RW-1:0] active_d, active_q;
  logic [PW-1:0] width;
  logic          pwm_d, pwm_q;
  logic [31:0]   rate_ext;

  assign rate_ext = 32'(rate);

  always_comb begin
    cond = RW'(rate);
    if (rate[BIT_WIDTH-1])            cond = '0;
    else if (rate_ext > 32'(RANGE))   cond = RW'(RANGE);
  end

  // A valid on the boundary edge loads the shadow only; active takes the
  // pre-edge shadow, so that value waits for the next frame.
  always_comb begin
    shadow_d = rates_valid ? cond : shadow_q;
    active_d = active_q;
    if (clr_act)       active_d = '0;
    else if (load_act) active_d = shadow_q;
  end

  always_comb begin
    width = '0;
    if (out_en) width = add_rate ? PW'(MIN_PULSE_US) + PW'(active_q) : PW'(MIN_PULSE_US);
    pwm_d = 32'(us_cnt) < 32'(width);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;
endmodule

module motor_pwm_driver #(
  parameter int BIT_WIDTH      = 16,
  parameter int TICKS_PER_US   = 38,
  parameter int PERIOD_US      = 2500,
  parameter int MIN_PULSE_US   = 1000,
  parameter int MAX_PULSE_US   = 2000,
  parameter int ARM_FRAMES     = 200,
  parameter int TIMEOUT_FRAMES = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] motor1_rate,
  input  logic [BIT_WIDTH-1:0] motor2_rate,
  input  logic [BIT_WIDTH-1:0] motor3_rate,
  input  logic [BIT_WIDTH-1:0] motor4_rate,
  input  logic                 rates_valid,
  input  logic                 arm_req,
  output logic [3:0]           pwm,
  output logic                 armed,
  output logic                 fault,
  output logic                 frame_start
);
  localparam int NUM_LANES = 4;
  localparam int RANGE = MAX_PULSE_US - MIN_PULSE_US;
  localparam int RW    = $clog2(RANGE + 1);
  localparam int PW    = $clog2(MAX_PULSE_US + 1);
  localparam int UW    = $clog2(PERIOD_US);
  localparam int TW    = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int AW    = $clog2(ARM_FRAMES + 1);
  localparam int OW    = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [1:0] {S_DISARMED, S_ARMING, S_ARMED, S_FAULT} state_e;

  state_e        state_d, state_q;
  logic [TW-1:0] tick_cnt_d, tick_cnt_q;
  logic [UW-1:0] us_cnt_d, us_cnt_q;
  logic [AW-1:0] arm_cnt_d, arm_cnt_q;
  logic [OW-1:0] to_cnt_d, to_cnt_q;
  logic          seen_d, seen_q;
  logic          armed_d, armed_q, fault_d, fault_q, frame_start_q;
  logic          us_tick, frame_wrap;
  logic [NUM_LANES-1:0][BIT_WIDTH-1:0] rate_v;

  assign rate_v = {motor4_rate, motor3_rate, motor2_rate, motor1_rate};

  // Timebase
  assign us_tick    = tick_cnt_q == TW'(TICKS_PER_US - 1);
  assign frame_wrap = us_tick && (us_cnt_q == UW'(PERIOD_US - 1));

  always_comb begin
    tick_cnt_d = us_tick ? '0 : tick_cnt_q + 1'b1;
    us_cnt_d   = us_cnt_q;
    if (frame_wrap)   us_cnt_d = '0;
    else if (us_tick) us_cnt_d = us_cnt_q + 1'b1;
  end

  // Arming / watchdog FSM, advanced only at frame boundaries. seen_q
  // records a valid in the frame now ending; a valid on the boundary edge
  // itself belongs to the new frame.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    to_cnt_d  = to_cnt_q;
    seen_d    = frame_wrap ? rates_valid : (seen_q | rates_valid);
    if (frame_wrap) begin
      unique case (state_q)
        S_DISARMED: if (arm_req) begin
          state_d   = S_ARMING;
          arm_cnt_d = '0;
        end
        S_ARMING: begin
          if (!arm_req) state_d = S_DISARMED;
          else if (arm_cnt_q == AW'(ARM_FRAMES - 1)) begin
            state_d  = S_ARMED;
            to_cnt_d = '0;
          end else arm_cnt_d = arm_cnt_q + 1'b1;
        end
        S_ARMED: begin
          // Disarm wins over a coincident timeout.
          if (!arm_req)                                  state_d  = S_DISARMED;
          else if (seen_q)                               to_cnt_d = '0;
          else if (to_cnt_q == OW'(TIMEOUT_FRAMES - 1))  state_d  = S_FAULT;
          else                                           to_cnt_d = to_cnt_q + 1'b1;
        end
        S_FAULT: if (!arm_req) state_d = S_DISARMED;
        default: state_d = S_DISARMED;
      endcase
    end
    armed_d = state_d == S_ARMED;
    fault_d = state_d == S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_DISARMED;
      tick_cnt_q    <= '0;
      us_cnt_q      <= '0;
      arm_cnt_q     <= '0;
      to_cnt_q      <= '0;
      seen_q        <= 1'b0;
      armed_q       <= 1'b0;
      fault_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      us_cnt_q      <= us_cnt_d;
      arm_cnt_q     <= arm_cnt_d;
      to_cnt_q      <= to_cnt_d;
      seen_q        <= seen_d;
      armed_q       <= armed_d;
      fault_q       <= fault_d;
      frame_start_q <= frame_wrap;
    end
  end

  // Width selection uses state_q, which only moves on the boundary edge,
  // so every pulse of a frame is generated with one consistent width.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    motor_pwm_lane #(
      .BIT_WIDTH(BIT_WIDTH), .RANGE(RANGE), .RW(RW), .PW(PW), .UW(UW),
      .MIN_PULSE_US(MIN_PULSE_US)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .rate       (rate_v[g]),
      .rates_valid(rates_valid),
      .load_act   (frame_wrap),
      .clr_act    (frame_wrap && (state_d == S_FAULT)),
      .out_en     (state_q != S_DISARMED),
      .add_rate   (state_q == S_ARMED),
      .us_cnt     (us_cnt_q),
      .pwm        (pwm[g])
    );
  end

  assign armed       = armed_q;
  assign fault       = fault_q;
  assign frame_start = frame_start_q;
endmodule
